addsub_mp: RTL and testbench

- Multi-precision adder/subtractor for wide operands.
- Processes a W = DBW*NCHUNK bit operation as NCHUNK sequential DBW-bit chunk operations, least significant chunk first.
- Chains the carry/borrow between chunks and produces carry, overflow, zero and negative flags.
- Uses a start/busy/done handshake. Serves as the wide-arithmetic unit for ALU extensions and the multi-byte math helpers.

---
 rtl/addsub_mp_if.sv | 53 +++++
 rtl/addsub_mp.sv | 272 +++++++++++++++++++++++++++
 tb/tb_addsub_mp.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_mp_if.sv
// ---------------------------------------------------------------------------
// addsub_mp_if
// Handshake and operand/result bundle for the multi-precision adder/subtractor.
//
// Parameters:
//   DBW    - chunk width in bits
//   NCHUNK - number of chunks; full operand width W = DBW*NCHUNK
//
// Signals:
//   start        request a new operation (sampled only when the unit is idle/done)
//   op           0 = add, 1 = subtract
//   dec          1 = BCD arithmetic (only meaningful when DECIMAL_EN is compiled in)
//   ci           carry in; for subtract, 1 = no borrow in
//   a, b         W-bit operands
//   busy         high while chunks are being computed
//   done         single-cycle completion strobe
//   o            W-bit result
//   co, v, z, n  carry out, signed overflow, zero, negative flags
//
// Modports:
//   master - the requester (drives start/op/dec/ci/a/b)
//   slave  - the arithmetic unit
// ---------------------------------------------------------------------------
interface addsub_mp_if #(
    parameter int DBW    = 8,
    parameter int NCHUNK = 4
);
    localparam int W = DBW * NCHUNK;

    logic         start;
    logic         op;
    logic         dec;
    logic         ci;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] o;
    logic         co;
    logic         v;
    logic         z;
    logic         n;

    modport master (
        output start, op, dec, ci, a, b,
        input  busy, done, o, co, v, z, n
    );

    modport slave (
        input  start, op, dec, ci, a, b,
        output busy, done, o, co, v, z, n
    );
endinterface

// File: rtl/addsub_mp.sv
// ---------------------------------------------------------------------------
// addsub_mp
// Multi-precision adder/subtractor. A W = DBW*NCHUNK bit add or subtract is
// carried out as NCHUNK sequential DBW-bit chunk operations, least significant
// chunk first, with the carry/borrow chained between chunks. Carry, overflow,
// zero and negative flags are produced when the last chunk is written.
//
// Optional feature (compile-time macro DECIMAL_EN):
//   When defined and dec is latched high, every 4-bit digit is computed in BCD
//   with the digit carry chained across digits and chunks. Without the macro
//   the dec input is ignored and no BCD logic is built.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset; aborts any operation in flight
//   bus    - addsub_mp_if.slave: start/op/dec/ci/a/b in,
//            busy/done/o/co/v/z/n out
//
// Timing: start sampled at edge k -> chunk i written at edge k+1+i ->
// done high in the cycle following edge k+NCHUNK. start is accepted in the
// DONE cycle, so back-to-back operations run every NCHUNK+1 cycles.
// ---------------------------------------------------------------------------
module addsub_mp #(
    parameter int DBW    = 8,
    parameter int NCHUNK = 4
) (
    input  logic         clk,
    input  logic         reset,
    addsub_mp_if.slave   bus
);
    localparam int W  = DBW * NCHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [IW-1:0]   idx_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            op_reg;
    logic            bc_reg;          // binary carry chained between chunks
    logic            co_reg;
    logic            v_reg;
    logic            z_reg;
    logic            n_reg;

    logic            busy_out;
    logic            done_out;
    logic            accept;
    logic            last_chunk;

    logic [DBW-1:0]  a_chunks [NCHUNK];
    logic [DBW-1:0]  b_chunks [NCHUNK];
    logic [W-1:0]    o_all;

    logic [DBW-1:0]  a_ch;
    logic [DBW-1:0]  b_ch;
    logic [DBW-1:0]  b_eff;
    logic [DBW:0]    bin_sum;
    logic [DBW-1:0]  res_ch;
    logic            res_co;
    logic            low_zero;
    logic            v_next;

    // -----------------------------------------------------------------------
    // Per-chunk operand views and result registers
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            logic [DBW-1:0] o_chunk_reg;

            assign a_chunks[gi] = a_reg[gi*DBW +: DBW];
            assign b_chunks[gi] = b_reg[gi*DBW +: DBW];
            assign o_all[gi*DBW +: DBW] = o_chunk_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    o_chunk_reg <= '0;
                end else if (state_reg == S_RUN && idx_reg == IW'(gi)) begin
                    o_chunk_reg <= res_ch;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign accept     = bus.start && (state_reg != S_RUN);
    assign last_chunk = (idx_reg == IW'(NCHUNK - 1));

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_RUN;
            S_RUN:   if (last_chunk) state_next = S_DONE;
            S_DONE:  state_next = bus.start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_out = 1'b0;
        done_out = 1'b0;
        case (state_reg)
            S_RUN:   busy_out = 1'b1;
            S_DONE:  done_out = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Binary chunk adder. Subtract is a + ~b + c, so c = 1 means "no borrow".
    // This path is always active: in decimal mode it still supplies the
    // binary top bit used by the overflow flag.
    // -----------------------------------------------------------------------
    always_comb begin
        a_ch    = a_chunks[idx_reg];
        b_ch    = b_chunks[idx_reg];
        b_eff   = op_reg ? ~b_ch : b_ch;
        bin_sum = {1'b0, a_ch} + {1'b0, b_eff} + {{DBW{1'b0}}, bc_reg};
    end

`ifdef DECIMAL_EN
    localparam int ND = DBW / 4;

    logic           dec_reg;
    logic           dc_reg;           // decimal digit carry chained across chunks
    logic [DBW-1:0] bcd_res;
    logic           bcd_co;

    // Digit-serial BCD chain inside one chunk, least significant digit first.
    always_comb begin : bcd_chain
        logic       c;
        logic [4:0] t;
        logic [3:0] ad;
        logic [3:0] bd;
        logic [3:0] s;
        c       = dc_reg;
        t       = '0;
        ad      = '0;
        bd      = '0;
        s       = '0;
        bcd_res = '0;
        for (int i = 0; i < ND; i++) begin
            ad = a_ch[4*i +: 4];
            bd = b_ch[4*i +: 4];
            if (!op_reg) begin
                t = {1'b0, ad} + {1'b0, bd} + {4'b0000, c};
                if (t > 5'd9) begin
                    s = t[3:0] + 4'd6;
                    c = 1'b1;
                end else begin
                    s = t[3:0];
                    c = 1'b0;
                end
            end else begin
                // t[4] set means the digit borrowed.
                t = {1'b0, ad} - {1'b0, bd} - {4'b0000, ~c};
                if (t[4]) begin
                    s = t[3:0] - 4'd6;
                    c = 1'b0;
                end else begin
                    s = t[3:0];
                    c = 1'b1;
                end
            end
            bcd_res[4*i +: 4] = s;
        end
        bcd_co = c;
    end

    always_comb begin
        res_ch = dec_reg ? bcd_res : bin_sum[DBW-1:0];
        res_co = dec_reg ? bcd_co  : bin_sum[DBW];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_reg <= 1'b0;
            dc_reg  <= 1'b0;
        end else if (accept) begin
            dec_reg <= bus.dec;
            dc_reg  <= bus.ci;
        end else if (state_reg == S_RUN) begin
            dc_reg  <= bcd_co;
        end
    end
`else
    // dec has no effect in a binary-only build.
    logic unused_dec;
    assign unused_dec = bus.dec;

    always_comb begin
        res_ch = bin_sum[DBW-1:0];
        res_co = bin_sum[DBW];
    end
`endif

    // -----------------------------------------------------------------------
    // Flag computation for the final chunk. Lower chunks are already in the
    // result registers; the top chunk is still on res_ch.
    // -----------------------------------------------------------------------
    always_comb begin
        low_zero = 1'b1;
        for (int i = 0; i < NCHUNK - 1; i++) begin
            if (o_all[i*DBW +: DBW] != '0) low_zero = 1'b0;
        end
        // Overflow always uses the binary top bit, even for BCD results.
        v_next = (op_reg ^ bin_sum[DBW-1] ^ b_reg[W-1]) &
                 (~op_reg ^ a_reg[W-1] ^ b_reg[W-1]);
    end

    // -----------------------------------------------------------------------
    // Operand latch, chunk index, carry chain and flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= 1'b0;
            bc_reg  <= 1'b0;
            co_reg  <= 1'b0;
            v_reg   <= 1'b0;
            z_reg   <= 1'b0;
            n_reg   <= 1'b0;
        end else if (accept) begin
            idx_reg <= '0;
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            op_reg  <= bus.op;
            bc_reg  <= bus.ci;
        end else if (state_reg == S_RUN) begin
            bc_reg <= bin_sum[DBW];
            if (last_chunk) begin
                idx_reg <= '0;
                co_reg  <= res_co;
                v_reg   <= v_next;
                z_reg   <= low_zero && (res_ch == '0);
                n_reg   <= res_ch[DBW-1];
            end else begin
                idx_reg <= idx_reg + IW'(1);
            end
        end
    end

    assign bus.busy = busy_out;
    assign bus.done = done_out;
    assign bus.o    = o_all;
    assign bus.co   = co_reg;
    assign bus.v    = v_reg;
    assign bus.z    = z_reg;
    assign bus.n    = n_reg;

endmodule

// File: tb/tb_addsub_mp.sv
// ---------------------------------------------------------------------------
// tb_addsub_mp
// Directed vectors for addsub_mp (DBW=8, NCHUNK=4). Stimulus pushes the
// hand-computed expected response and completion cycle into a queue; a
// separate monitor pops and compares whenever done is seen.
// Define DECIMAL_EN to include the BCD vectors.
// ---------------------------------------------------------------------------
module tb_addsub_mp;
    localparam int DBW    = 8;
    localparam int NCHUNK = 4;
    localparam int W      = DBW * NCHUNK;

    typedef struct {
        logic [W-1:0] o;
        logic         co;
        logic         v;
        logic         z;
        logic         n;
        int           cyc;
        string        name;
    } exp_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   cyc;
    int   busy_cnt;
    exp_t q[$];

    addsub_mp_if #(.DBW(DBW), .NCHUNK(NCHUNK)) bus ();

    addsub_mp #(.DBW(DBW), .NCHUNK(NCHUNK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor / scoreboard
    initial begin
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.busy) busy_cnt = busy_cnt + 1;
            if (bus.done) begin
                if (q.size() == 0) begin
                    tests = tests + 1;
                    fails = fails + 1;
                    $display("FAIL unexpected_done: got done=1 o=%h expected no done", bus.o);
                end else begin
                    e = q.pop_front();
                    chk({e.name, ".o"},       64'(bus.o),  64'(e.o));
                    chk({e.name, ".co"},      64'(bus.co), 64'(e.co));
                    chk({e.name, ".v"},       64'(bus.v),  64'(e.v));
                    chk({e.name, ".z"},       64'(bus.z),  64'(e.z));
                    chk({e.name, ".n"},       64'(bus.n),  64'(e.n));
                    chk({e.name, ".latency"}, 64'(cyc),    64'(e.cyc));
                    chk({e.name, ".busy"},    64'(busy_cnt), 64'(NCHUNK));
                    $display("[TB] %s o=%h co=%b v=%b z=%b n=%b", e.name, bus.o, bus.co, bus.v, bus.z, bus.n);
                end
                busy_cnt = 0;
            end else if (!bus.busy) begin
                busy_cnt = 0;
            end
        end
    end

    // Issues one start pulse; caller is positioned just after a negedge.
    task automatic do_op(input logic op_i, input logic dec_i, input logic ci_i,
                         input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input logic [W-1:0] eo, input logic eco, input logic ev,
                         input logic ez, input logic en, input string nm, input bit push);
        exp_t e;
        bus.op    = op_i;
        bus.dec   = dec_i;
        bus.ci    = ci_i;
        bus.a     = a_i;
        bus.b     = b_i;
        bus.start = 1'b1;
        if (push) begin
            e.o = eo; e.co = eco; e.v = ev; e.z = ez; e.n = en;
            e.cyc = cyc + NCHUNK + 1;
            e.name = nm;
            q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        // Scramble inputs: they must not affect the operation in flight.
        bus.op = ~op_i;
        bus.ci = ~ci_i;
        bus.a  = ~a_i;
        bus.b  = ~b_i;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (q.size() != 0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic run_op(input logic op_i, input logic dec_i, input logic ci_i,
                          input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input logic [W-1:0] eo, input logic eco, input logic ev,
                          input logic ez, input logic en, input string nm);
        @(negedge clk);
        #1;
        do_op(op_i, dec_i, ci_i, a_i, b_i, eo, eco, ev, ez, en, nm, 1'b1);
        wait_drain();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".busy"}, 64'(bus.busy), 64'd0);
        chk({nm, ".done"}, 64'(bus.done), 64'd0);
        chk({nm, ".o"},    64'(bus.o),    64'd0);
        chk({nm, ".co"},   64'(bus.co),   64'd0);
        chk({nm, ".v"},    64'(bus.v),    64'd0);
        chk({nm, ".z"},    64'(bus.z),    64'd0);
        chk({nm, ".n"},    64'(bus.n),    64'd0);
    endtask

    initial begin
        int k;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 1'b0;
        bus.dec = 1'b0;
        bus.ci = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        $display("[TB] reset state checked");
        reset = 1'b0;

        // Basic add/sub with flag corners
        run_op(1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, "add_ovf");
        run_op(1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, "sub_borrow");
        run_op(1'b1, 1'b0, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, "sub_ovf");
        run_op(1'b1, 1'b0, 1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, "sub_zero");
        run_op(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, "add_wrap");
        run_op(1'b1, 1'b0, 1'b0, 32'h00000005, 32'h00000003, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, "sub_bin0");
        run_op(1'b0, 1'b0, 1'b1, 32'h12345678, 32'h11111111, 32'h2345678A, 1'b0, 1'b0, 1'b0, 1'b0, "add_ci1");

        // start during RUN ignored, then start in DONE accepted back-to-back
        @(negedge clk);
        #1;
        do_op(1'b0, 1'b0, 1'b0, 32'h00000100, 32'h000000FF, 32'h000001FF, 1'b0, 1'b0, 1'b0, 1'b0, "run_pulse", 1'b1);
        bus.start = 1'b1;
        bus.a = 32'hDEADBEEF;
        bus.b = 32'h01234567;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("b2b.first_done_seen", 64'(bus.done), 64'd1);
        do_op(1'b1, 1'b0, 1'b1, 32'h40000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, "b2b_second", 1'b1);
        wait_drain();
        repeat (6) @(negedge clk);

        // Reset after two chunks of RUN aborts the operation
        @(negedge clk);
        #1;
        do_op(1'b0, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "aborted", 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("abort");
        $display("[TB] mid-RUN reset checked");
        repeat (10) @(negedge clk);
        run_op(1'b0, 1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0, "after_abort");

`ifdef DECIMAL_EN
        run_op(1'b0, 1'b1, 1'b0, 32'h00000999, 32'h00000001, 32'h00001000, 1'b0, 1'b0, 1'b0, 1'b0, "bcd_add");
        run_op(1'b1, 1'b1, 1'b1, 32'h00001000, 32'h00000001, 32'h00000999, 1'b1, 1'b0, 1'b0, 1'b0, "bcd_sub");
        run_op(1'b0, 1'b1, 1'b0, 32'h99999999, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, "bcd_wrap");
`else
        // dec is ignored: binary result
        run_op(1'b0, 1'b1, 1'b0, 32'h00000999, 32'h00000001, 32'h0000099A, 1'b0, 1'b0, 1'b0, 1'b0, "dec_ignored");
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
